fx2_sfifo_model: RTL and testbench

//  Synthesizable model of the EZ-USB FX2 slave-FIFO side of the high-speed I/O bus, the counterpart of the FPGA-side hs_io master.

---
 rtl/fx2_sfifo_pkg.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/fx2_sfifo_model.sv | 169 ++++++++++++++++
 tb/tb_fx2_sfifo_model.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_sfifo_pkg.sv
// fx2_sfifo_pkg: shared constants and types for the FX2 slave-FIFO model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FIFOADR endpoint codes, bus word width, FX2 high-speed packet size, EP_WR store word.
package fx2_sfifo_pkg;

  // FIFOADR codes {FIFOADR1,FIFOADR0} of the four FX2 endpoint FIFOs.
  typedef enum logic [1:0] {
    FIFOADR_EP2 = 2'b00,
    FIFOADR_EP4 = 2'b01,
    FIFOADR_EP6 = 2'b10,
    FIFOADR_EP8 = 2'b11
  } fifoadr_e;

  localparam int WORD_W        = 16;
  localparam int FX2_PKT_BYTES = 512;
  localparam int FX2_PKT_WORDS = FX2_PKT_BYTES / (WORD_W / 8);

  // One EP_WR store entry: payload plus end-of-packet marker.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } wr_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO, 2^AW entries of W bits.
// Latency: head_dat_o is the oldest word combinationally; a pushed word is visible after its edge.
// Backpressure: push_i ignored while full_o; pop_i ignored while empty_o.
// Ports: clk, rst_n (synchronous, active-low), push_i/push_dat_i, pop_i, head_dat_o,
//        full_o, empty_o, count_next_o (occupancy after the current edge, for registered flags).
module sync_fifo_fwft #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_next_o
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(1) << AW;

  logic [W-1:0]  mem_q [1 << AW];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  assign count_next_o = rst_n ? count_d : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fx2_sfifo_model.sv
// fx2_sfifo_model: EZ-USB FX2 slave-FIFO counterpart of the FPGA hs_io master (EP_RD host->FPGA, EP_WR FPGA->host).
// Latency: fifo_data_out/fifo_data_oe combinational; FLAGB/FLAGC registered from post-edge occupancy
//          (plus 3 extra register stages when SFIFO_FLAG_DELAY_EN is defined).
// Backpressure: SLRD on empty EP_RD and SLWR on full EP_WR are dropped and flagged; host push/pop ignored while full/empty.
// Ports: IFCLK, RESET_N (sync active-low), FIFOADR/SLOE/SLRD/SLWR/PKTEND strobes (active-low), FLAGB (EP_WR full_n),
//        FLAGC (EP_RD empty_n), fifo_data_in/out/oe bus, host_din/wr_en/full push side of EP_RD,
//        host_dout/last/rd_en/empty FWFT pop side of EP_WR, sticky err_underrun/err_overrun/err_protocol.
// Optional macro: SFIFO_FLAG_DELAY_EN adds the FX2-like flag pipeline.
module fx2_sfifo_model
  import fx2_sfifo_pkg::*;
#(
  parameter logic [1:0] EP_RD_ADDR = FIFOADR_EP2,
  parameter logic [1:0] EP_WR_ADDR = FIFOADR_EP6,
  parameter int         DEPTH_LOG2 = 10,
  parameter int         PKT_WORDS  = FX2_PKT_WORDS
) (
  input  logic              IFCLK,
  input  logic              RESET_N,
  input  logic [1:0]        FIFOADR,
  input  logic              SLOE,
  input  logic              SLRD,
  input  logic              SLWR,
  input  logic              PKTEND,
  output logic              FLAGB,
  output logic              FLAGC,
  input  logic [WORD_W-1:0] fifo_data_in,
  output logic [WORD_W-1:0] fifo_data_out,
  output logic              fifo_data_oe,
  input  logic [WORD_W-1:0] host_din,
  input  logic              host_wr_en,
  output logic              host_full,
  output logic [WORD_W-1:0] host_dout,
  output logic              host_last,
  input  logic              host_rd_en,
  output logic              host_empty,
  output logic              err_underrun,
  output logic              err_overrun,
  output logic              err_protocol
);

  localparam logic [DEPTH_LOG2:0] FULL_OCC = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PKT_OCC  = (DEPTH_LOG2 + 1)'(PKT_WORDS);

  // ---------------- strobe decode ----------------
  logic rd_sel, wr_sel, fpga_rd, fpga_wr, fpga_pktend, protocol_bad;

  assign rd_sel       = (FIFOADR == EP_RD_ADDR);
  assign wr_sel       = (FIFOADR == EP_WR_ADDR);
  assign fpga_rd      = !SLRD && rd_sel;
  assign fpga_wr      = !SLWR && wr_sel;
  assign fpga_pktend  = !PKTEND && wr_sel;
  assign protocol_bad = ((!SLRD || !SLOE) && !rd_sel) || ((!SLWR || !PKTEND) && !wr_sel);

  // ---------------- EP_RD: host -> FPGA ----------------
  logic                rd_empty;
  logic [DEPTH_LOG2:0] rd_occ_next;

  assign fifo_data_oe = !SLOE && rd_sel;

  // SLOE deliberately does not gate the pop: the FX2 advances on SLRD alone.
  sync_fifo_fwft #(
    .W  (WORD_W),
    .AW (DEPTH_LOG2)
  ) u_ep_rd (
    .clk          (IFCLK),
    .rst_n        (RESET_N),
    .push_i       (host_wr_en),
    .push_dat_i   (host_din),
    .pop_i        (fpga_rd),
    .head_dat_o   (fifo_data_out),
    .full_o       (host_full),
    .empty_o      (rd_empty),
    .count_next_o (rd_occ_next)
  );

  // ---------------- EP_WR: FPGA -> host, packetised ----------------
  wr_word_t              wr_mem_q [1 << DEPTH_LOG2];
  wr_word_t              head_w;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, host_ptr_q, host_ptr_d, wr_last_ptr;
  logic [DEPTH_LOG2:0]   wr_occ_q, wr_occ_d, pend_q, pend_d, pend_inc;
  logic                  wr_full, wr_accept, host_pop, commit;

  // wr_occ_q counts committed + pending words; the committed share is what the host may see.
  assign wr_full     = (wr_occ_q == FULL_OCC);
  assign wr_accept   = fpga_wr && !wr_full;
  assign host_empty  = (wr_occ_q == pend_q);
  assign host_pop    = host_rd_en && !host_empty;
  assign pend_inc    = pend_q + (DEPTH_LOG2 + 1)'(wr_accept);
  assign wr_last_ptr = wr_ptr_q - DEPTH_LOG2'(1);

  // Same-edge SLWR+PKTEND includes the word first; zero-length PKTEND is a no-op.
  assign commit = (pend_inc == PKT_OCC) || (fpga_pktend && (pend_inc != '0));

  always_comb begin
    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(wr_accept);
    host_ptr_d = host_ptr_q + DEPTH_LOG2'(host_pop);
    pend_d     = commit ? '0 : pend_inc;
    wr_occ_d   = wr_occ_q + (DEPTH_LOG2 + 1)'(wr_accept) - (DEPTH_LOG2 + 1)'(host_pop);
  end

  assign head_w    = wr_mem_q[host_ptr_q];
  assign host_dout = head_w.data;
  assign host_last = head_w.last && !host_empty;

  // A committing write carries its own last bit; a bare PKTEND retro-marks the previous word.
  always_ff @(posedge IFCLK) begin
    if (RESET_N) begin
      if (wr_accept) begin
        wr_mem_q[wr_ptr_q] <= '{last: commit, data: fifo_data_in};
      end else if (commit) begin
        wr_mem_q[wr_last_ptr].last <= 1'b1;
      end
    end
  end

  // ---------------- state, flags, sticky errors ----------------
  logic flagb_q, flagc_q, err_underrun_q, err_overrun_q, err_protocol_q;

  always_ff @(posedge IFCLK) begin
    if (!RESET_N) begin
      wr_ptr_q       <= '0;
      host_ptr_q     <= '0;
      wr_occ_q       <= '0;
      pend_q         <= '0;
      flagb_q        <= 1'b1;
      flagc_q        <= 1'b0;
      err_underrun_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      host_ptr_q     <= host_ptr_d;
      wr_occ_q       <= wr_occ_d;
      pend_q         <= pend_d;
      flagb_q        <= (wr_occ_d != FULL_OCC);
      flagc_q        <= (rd_occ_next != '0);
      err_underrun_q <= err_underrun_q | (fpga_rd && rd_empty);
      err_overrun_q  <= err_overrun_q | (fpga_wr && wr_full);
      err_protocol_q <= err_protocol_q | protocol_bad;
    end
  end

  assign err_underrun = err_underrun_q;
  assign err_overrun  = err_overrun_q;
  assign err_protocol = err_protocol_q;

`ifdef SFIFO_FLAG_DELAY_EN
  // Flags lag occupancy by three more cycles, like the real FX2; the datapath still
  // uses true occupancy, so strobes issued in the lag window are dropped and flagged.
  logic [2:0] flagb_pipe_q, flagc_pipe_q;

  always_ff @(posedge IFCLK) begin
    if (!RESET_N) begin
      flagb_pipe_q <= 3'b111;
      flagc_pipe_q <= 3'b000;
    end else begin
      flagb_pipe_q <= {flagb_pipe_q[1:0], flagb_q};
      flagc_pipe_q <= {flagc_pipe_q[1:0], flagc_q};
    end
  end

  assign FLAGB = flagb_pipe_q[2];
  assign FLAGC = flagc_pipe_q[2];
`else
  assign FLAGB = flagb_q;
  assign FLAGC = flagc_q;
`endif

endmodule

// File: tb/tb_fx2_sfifo_model.sv
module tb_fx2_sfifo_model;

  localparam int DEPTH = 1024;
  localparam int PKT   = 256;
`ifdef SFIFO_FLAG_DELAY_EN
  localparam int FLAG_LAT = 3;
`else
  localparam int FLAG_LAT = 0;
`endif

  logic        IFCLK = 1'b0;
  logic        RESET_N, SLOE, SLRD, SLWR, PKTEND, host_wr_en, host_rd_en;
  logic [1:0]  FIFOADR;
  logic [15:0] fifo_data_in, host_din;
  logic        FLAGB, FLAGC, fifo_data_oe, host_full, host_last, host_empty;
  logic        err_underrun, err_overrun, err_protocol;
  logic [15:0] fifo_data_out, host_dout;

  always #5 IFCLK = ~IFCLK;

  fx2_sfifo_model dut (
    .IFCLK         (IFCLK),
    .RESET_N       (RESET_N),
    .FIFOADR       (FIFOADR),
    .SLOE          (SLOE),
    .SLRD          (SLRD),
    .SLWR          (SLWR),
    .PKTEND        (PKTEND),
    .FLAGB         (FLAGB),
    .FLAGC         (FLAGC),
    .fifo_data_in  (fifo_data_in),
    .fifo_data_out (fifo_data_out),
    .fifo_data_oe  (fifo_data_oe),
    .host_din      (host_din),
    .host_wr_en    (host_wr_en),
    .host_full     (host_full),
    .host_dout     (host_dout),
    .host_last     (host_last),
    .host_rd_en    (host_rd_en),
    .host_empty    (host_empty),
    .err_underrun  (err_underrun),
    .err_overrun   (err_overrun),
    .err_protocol  (err_protocol)
  );

  // ---------------- reference model: plain queues ----------------
  logic [15:0] rdq[$];          // EP_RD contents, head first
  logic [16:0] cq[$];           // EP_WR committed {last,data}
  logic [16:0] pq[$];           // EP_WR pending {last,data}
  bit          m_under, m_over, m_proto;
  bit          flagb_h[4];      // flag history, [0] = value from the latest edge
  bit          flagc_h[4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rdq.delete();
    cq.delete();
    pq.delete();
    m_under = 0;
    m_over  = 0;
    m_proto = 0;
    for (int i = 0; i < 4; i++) begin
      flagb_h[i] = 1'b1;
      flagc_h[i] = 1'b0;
    end
  endtask

  // Apply one clock edge's worth of the rules to the queues, using pre-edge state.
  task automatic model_edge();
    bit          rd_sel, wr_sel, fpga_pop, host_push, wr_try, wr_ok, hpop;
    logic [16:0] tmp;
    rd_sel    = (FIFOADR == 2'b00);
    wr_sel    = (FIFOADR == 2'b10);
    fpga_pop  = !SLRD && rd_sel && (rdq.size() > 0);
    host_push = host_wr_en && (rdq.size() < DEPTH);
    wr_try    = !SLWR && wr_sel;
    wr_ok     = wr_try && ((cq.size() + pq.size()) < DEPTH);
    hpop      = host_rd_en && (cq.size() > 0);
    if (!SLRD && rd_sel && rdq.size() == 0) m_under = 1;
    if (wr_try && !wr_ok) m_over = 1;
    if (((!SLRD || !SLOE) && !rd_sel) || ((!SLWR || !PKTEND) && !wr_sel)) m_proto = 1;
    if (fpga_pop)  void'(rdq.pop_front());
    if (host_push) rdq.push_back(host_din);
    if (hpop)      void'(cq.pop_front());
    if (wr_ok)     pq.push_back({1'b0, fifo_data_in});
    if (pq.size() > 0 && (pq.size() == PKT || (!PKTEND && wr_sel))) begin
      tmp = pq[pq.size() - 1];
      tmp[16] = 1'b1;
      pq[pq.size() - 1] = tmp;
      foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete();
    end
    for (int i = 3; i > 0; i--) begin
      flagb_h[i] = flagb_h[i - 1];
      flagc_h[i] = flagc_h[i - 1];
    end
    flagb_h[0] = ((cq.size() + pq.size()) != DEPTH);
    flagc_h[0] = (rdq.size() != 0);
  endtask

  task automatic check_all(input string tag);
    logic [16:0] head;
    chk1({tag, ".FLAGB"}, FLAGB, flagb_h[FLAG_LAT]);
    chk1({tag, ".FLAGC"}, FLAGC, flagc_h[FLAG_LAT]);
    chk1({tag, ".oe"}, fifo_data_oe, !SLOE && FIFOADR == 2'b00);
    if (rdq.size() > 0) chk16({tag, ".fifo_dout"}, fifo_data_out, rdq[0]);
    chk1({tag, ".host_full"}, host_full, rdq.size() == DEPTH);
    chk1({tag, ".host_empty"}, host_empty, cq.size() == 0);
    if (cq.size() > 0) begin
      head = cq[0];
      chk16({tag, ".host_dout"}, host_dout, head[15:0]);
      chk1({tag, ".host_last"}, host_last, head[16]);
    end else begin
      chk1({tag, ".host_last"}, host_last, 1'b0);
    end
    chk1({tag, ".err_underrun"}, err_underrun, m_under);
    chk1({tag, ".err_overrun"}, err_overrun, m_over);
    chk1({tag, ".err_protocol"}, err_protocol, m_proto);
  endtask

  // Inputs are already set; check settled outputs, advance the model, clock once.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_edge();
    @(posedge IFCLK);
    #1;
  endtask

  task automatic idle();
    SLOE = 1; SLRD = 1; SLWR = 1; PKTEND = 1;
    host_wr_en = 0; host_rd_en = 0;
    fifo_data_in = '0; host_din = '0;
  endtask

  task automatic apply_reset();
    RESET_N = 0;
    idle();
    repeat (2) @(posedge IFCLK);
    #1;
    RESET_N = 1;
    model_reset();
  endtask

  typedef struct {
    logic        hw;
    logic [15:0] hd;
    logic        sloe;
    logic        slrd;
    logic        dout_vld;
    logic [15:0] e_dout;
    logic        e_oe;
    logic        e_flagc;
    logic        e_under;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : main
    int cnt;
    int r;
    bit fill;

    FIFOADR = 2'b00;
    // ---- reset state ----
    apply_reset();
    chk1("reset.FLAGB", FLAGB, 1'b1);
    chk1("reset.FLAGC", FLAGC, 1'b0);
    chk1("reset.host_empty", host_empty, 1'b1);
    chk1("reset.host_full", host_full, 1'b0);
    chk1("reset.host_last", host_last, 1'b0);
    chk1("reset.oe", fifo_data_oe, 1'b0);
    chk1("reset.err_underrun", err_underrun, 1'b0);
    chk1("reset.err_overrun", err_overrun, 1'b0);
    chk1("reset.err_protocol", err_protocol, 1'b0);

    // ---- EP_RD: host pushes 1..4, FPGA reads 4, 5th read underruns ----
    //            hw hd  sloe slrd vld dout oe flagc under
    tbl[0] = '{1, 16'd1, 1, 1, 0, 16'd0, 0, 0, 0};
    tbl[1] = '{1, 16'd2, 1, 1, 1, 16'd1, 0, 1, 0};
    tbl[2] = '{1, 16'd3, 1, 1, 1, 16'd1, 0, 1, 0};
    tbl[3] = '{1, 16'd4, 1, 1, 1, 16'd1, 0, 1, 0};
    tbl[4] = '{0, 16'd0, 0, 0, 1, 16'd1, 1, 1, 0};
    tbl[5] = '{0, 16'd0, 0, 0, 1, 16'd2, 1, 1, 0};
    tbl[6] = '{0, 16'd0, 0, 0, 1, 16'd3, 1, 1, 0};
    tbl[7] = '{0, 16'd0, 0, 0, 1, 16'd4, 1, 1, 0};
    tbl[8] = '{0, 16'd0, 0, 0, 0, 16'd0, 1, 0, 0};
    tbl[9] = '{0, 16'd0, 1, 1, 0, 16'd0, 0, 0, 1};
    FIFOADR = 2'b00;
    for (int i = 0; i < 10; i++) begin
      host_wr_en = tbl[i].hw;
      host_din   = tbl[i].hd;
      SLOE       = tbl[i].sloe;
      SLRD       = tbl[i].slrd;
      #1;
      if (tbl[i].dout_vld) chk16($sformatf("tbl%0d.dout", i), fifo_data_out, tbl[i].e_dout);
      chk1($sformatf("tbl%0d.oe", i), fifo_data_oe, tbl[i].e_oe);
`ifndef SFIFO_FLAG_DELAY_EN
      chk1($sformatf("tbl%0d.FLAGC", i), FLAGC, tbl[i].e_flagc);
`endif
      chk1($sformatf("tbl%0d.err_underrun", i), err_underrun, tbl[i].e_under);
      step($sformatf("tbl%0d", i));
    end
    idle();

    // ---- 256 writes auto-commit, host drains in order ----
    FIFOADR = 2'b10;
    for (int i = 0; i < PKT; i++) begin
      SLWR = 0;
      fifo_data_in = 16'(16'h1000 + i);
      step("auto_wr");
    end
    idle();
    chk1("auto.host_empty_after_commit", host_empty, 1'b0);
    host_rd_en = 1;
    for (int i = 0; i < PKT; i++) begin
      chk16("auto.dout", host_dout, 16'(16'h1000 + i));
      chk1("auto.last", host_last, i == PKT - 1);
      step("auto_rd");
    end
    idle();
    chk1("auto.host_empty_after_drain", host_empty, 1'b1);

    // ---- short packet via PKTEND, then zero-length PKTEND ----
    for (int i = 0; i < 3; i++) begin
      SLWR = 0;
      fifo_data_in = 16'(16'h0A01 + i);
      step("short_wr");
    end
    idle();
    chk1("short.empty_before_pktend", host_empty, 1'b1);
    PKTEND = 0;
    step("short_pktend");
    idle();
    chk1("short.empty_after_pktend", host_empty, 1'b0);
    host_rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      chk16("short.dout", host_dout, 16'(16'h0A01 + i));
      chk1("short.last", host_last, i == 2);
      step("short_rd");
    end
    idle();
    PKTEND = 0;
    step("zlp");
    idle();
    step("zlp_idle");
    chk1("zlp.host_empty", host_empty, 1'b1);

    // ---- fill EP_WR to 1024, FLAGB timing, overrun, full drain ----
    for (int i = 0; i < DEPTH; i++) begin
      SLWR = 0;
      fifo_data_in = 16'(16'h4000 + i);
      step("fill_wr");
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("fill.FLAGB_k%0d", k), FLAGB, !(k >= FLAG_LAT));
      step("fill_wait");
    end
    chk1("fill.err_overrun_before", err_overrun, 1'b0);
    SLWR = 0;
    fifo_data_in = 16'hDEAD;
    step("overrun");
    idle();
    chk1("fill.err_overrun_after", err_overrun, 1'b1);
    host_rd_en = 1;
    cnt = 0;
    for (int c = 0; c < DEPTH + 50 && !host_empty; c++) begin
      cnt++;
      step("fill_rd");
    end
    idle();
    chk16("fill.drain_count", 16'(cnt), 16'(DEPTH));

    // ---- illegal strobe: SLWR on EP_RD address ----
    chk1("proto.before", err_protocol, 1'b0);
    FIFOADR = 2'b00;
    SLWR = 0;
    fifo_data_in = 16'hBEEF;
    step("proto");
    idle();
    step("proto_idle");
    chk1("proto.after", err_protocol, 1'b1);
    chk1("proto.host_empty", host_empty, 1'b1);

    // ---- reset mid-packet discards pending words ----
    FIFOADR = 2'b10;
    for (int i = 0; i < 5; i++) begin
      SLWR = 0;
      fifo_data_in = 16'(16'h7700 + i);
      step("midpkt_wr");
    end
    apply_reset();
    FIFOADR = 2'b10;
    chk1("midpkt.err_cleared", err_protocol, 1'b0);
    PKTEND = 0;
    step("midpkt_pktend");
    idle();
    step("midpkt_idle");
    chk1("midpkt.host_empty", host_empty, 1'b1);

    // ---- randomized traffic against the queue model ----
    for (int c = 0; c < 3000; c++) begin
      fill = (c % 1500) < 900;
      r = $urandom_range(0, 9);
      FIFOADR      = (r < 4) ? 2'b00 : (r < 9) ? 2'b10 : 2'($urandom_range(0, 3));
      SLOE         = ($urandom_range(0, 1) == 0);
      SLRD         = !($urandom_range(0, 9) < (fill ? 1 : 8));
      SLWR         = !($urandom_range(0, 9) < (fill ? 9 : 2));
      PKTEND       = ($urandom_range(0, 15) != 0);
      fifo_data_in = 16'($urandom);
      host_din     = 16'($urandom);
      host_wr_en   = ($urandom_range(0, 9) < (fill ? 9 : 1));
      host_rd_en   = ($urandom_range(0, 9) < (fill ? 1 : 8));
      step("rand");
    end
    idle();
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
